// File: rtl/pio_debounce_avalon.sv
// Avalon-MM GPIO slave: registered outputs, plus synchronised, debounced inputs
// with per-bit edge capture and a maskable level interrupt.
module pio_debounce_avalon #(
  parameter int                  IN_WIDTH        = 8,
  parameter int                  OUT_WIDTH       = 8,
  parameter int                  DEBOUNCE_CYCLES = 1000,
  parameter int                  EDGE_MODE       = 1,
  parameter logic [IN_WIDTH-1:0] IN_RESET_VAL    = '1
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic [1:0]           address,
  input  logic                 chipselect,
  input  logic                 read,
  input  logic                 write,
  input  logic [31:0]          writedata,
  output logic [31:0]          readdata,
  output logic                 irq,
  input  logic [IN_WIDTH-1:0]  pio_in,
  output logic [OUT_WIDTH-1:0] pio_out
);

  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [IN_WIDTH-1:0]             r_sync1, r_sync2;
  logic [IN_WIDTH-1:0]             r_stable, r_stable_d;
  logic [IN_WIDTH-1:0][CNT_W-1:0]  r_cnt;
  logic [IN_WIDTH-1:0]             r_edge, r_mask;
  logic [OUT_WIDTH-1:0]            r_out;
  logic [31:0]                     r_rdata;

  logic                w_wr, w_rd;
  logic [IN_WIDTH-1:0] w_rise, w_fall, w_ev, w_clr;
  logic [31:0]         w_rd_mux;
  logic                w_unused;

  assign w_wr     = chipselect & write;
  assign w_rd     = chipselect & read & ~write;
  assign w_unused = &{1'b0, writedata};

  // Sync flops start at the idle pin level so a quiet input yields no edge after reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_sync1 <= IN_RESET_VAL;
      r_sync2 <= IN_RESET_VAL;
    end else begin
      r_sync1 <= pio_in;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_stable   <= IN_RESET_VAL;
      r_stable_d <= IN_RESET_VAL;
      r_cnt      <= '0;
    end else begin
      r_stable_d <= r_stable;
      for (int i = 0; i < IN_WIDTH; i++) begin
        if (r_sync2[i] == r_stable[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_LAST) begin
          r_stable[i] <= r_sync2[i];
          r_cnt[i]    <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign w_rise = r_stable & ~r_stable_d;
  assign w_fall = ~r_stable & r_stable_d;

  always_comb begin
    w_ev = w_rise | w_fall;
    if (EDGE_MODE == 0)      w_ev = w_rise;
    else if (EDGE_MODE == 1) w_ev = w_fall;
  end

  assign w_clr = (w_wr && address == 2'd2) ? writedata[IN_WIDTH-1:0] : '0;

  always_comb begin
    w_rd_mux = '0;
    case (address)
      2'd0:    w_rd_mux = 32'(r_stable);
      2'd1:    w_rd_mux = 32'(r_out);
      2'd2:    w_rd_mux = 32'(r_edge);
      default: w_rd_mux = 32'(r_mask);
    endcase
  end

  // A new event wins over a same-cycle clear so no edge is ever lost.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_edge  <= '0;
      r_mask  <= '0;
      r_out   <= '0;
      r_rdata <= '0;
    end else begin
      r_edge <= (r_edge & ~w_clr) | w_ev;
      if (w_wr) begin
        case (address)
          2'd1:    r_out  <= writedata[OUT_WIDTH-1:0];
          2'd3:    r_mask <= writedata[IN_WIDTH-1:0];
          default: ;
        endcase
      end
      if (w_rd) r_rdata <= w_rd_mux;
    end
  end

  assign readdata = r_rdata;
  assign pio_out  = r_out;
  assign irq      = |(r_edge & r_mask);

endmodule

// File: tb/tb_pio_debounce_avalon.sv
// Bench for pio_debounce_avalon: directed scenarios then random traffic, all
// checked each cycle against a sliding-window reference model.
module tb_pio_debounce_avalon;

  localparam int       D   = 4;
  localparam logic [7:0] IRV = 8'hFF;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [1:0]  address;
  logic        chipselect, read, write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;
  logic [7:0]  pio_in;
  logic [7:0]  pio_out;

  pio_debounce_avalon #(
    .IN_WIDTH(8), .OUT_WIDTH(8), .DEBOUNCE_CYCLES(D), .EDGE_MODE(1), .IN_RESET_VAL(IRV)
  ) dut (
    .Clk(Clk), .Reset(Reset), .address(address), .chipselect(chipselect),
    .read(read), .write(write), .writedata(writedata), .readdata(readdata),
    .irq(irq), .pio_in(pio_in), .pio_out(pio_out)
  );

  always #5 Clk = ~Clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model state
  logic [7:0]  m_p1, m_p2, m_stable, m_stable_d, m_edge, m_mask, m_out;
  logic [31:0] m_rdata;
  logic [7:0]  hist[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] regval(input logic [1:0] a);
    case (a)
      2'd0:    return {24'b0, m_stable};
      2'd1:    return {24'b0, m_out};
      2'd2:    return {24'b0, m_edge};
      default: return {24'b0, m_mask};
    endcase
  endfunction

  // One clock: sample the driven inputs, advance model across the edge, compare.
  task automatic step();
    logic       c_rst, c_wr, c_rd;
    logic [1:0] c_a;
    logic [7:0] c_wd, c_pin, ev, clr, nst;
    bit         all;
    c_rst = Reset;
    c_wr  = chipselect && write;
    c_rd  = chipselect && read && !write;
    c_a   = address;
    c_wd  = writedata[7:0];
    c_pin = pio_in;
    @(posedge Clk);
    if (c_rst) begin
      m_p1 = IRV; m_p2 = IRV; m_stable = IRV; m_stable_d = IRV;
      m_edge = '0; m_mask = '0; m_out = '0; m_rdata = '0;
      hist.delete();
    end else begin
      ev  = m_stable_d & ~m_stable;
      clr = (c_wr && c_a == 2'd2) ? c_wd : 8'h00;
      if (c_rd) m_rdata = regval(c_a);
      // A bit flips once its last D synchronised samples all disagree with it.
      hist.push_back(m_p2);
      if (hist.size() > D) void'(hist.pop_front());
      nst = m_stable;
      if (hist.size() == D) begin
        for (int b = 0; b < 8; b++) begin
          all = 1'b1;
          foreach (hist[k]) if (hist[k][b] == m_stable[b]) all = 1'b0;
          if (all) nst[b] = ~m_stable[b];
        end
      end
      m_stable_d = m_stable;
      m_stable   = nst;
      m_p2 = m_p1;
      m_p1 = c_pin;
      m_edge = (m_edge & ~clr) | ev;
      if (c_wr && c_a == 2'd1) m_out  = c_wd;
      if (c_wr && c_a == 2'd3) m_mask = c_wd;
    end
    #1;
    check("readdata", readdata, m_rdata);
    check("pio_out", {24'b0, pio_out}, {24'b0, m_out});
    check("irq", {31'b0, irq}, {31'b0, |(m_edge & m_mask)});
  endtask

  task automatic idle();
    chipselect = 1'b0; read = 1'b0; write = 1'b0;
  endtask

  task automatic cyc(input int n);
    repeat (n) step();
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1; write = 1'b1; read = 1'b0; address = a; writedata = d;
    step();
    idle();
  endtask

  task automatic rd_reg(input logic [1:0] a, input logic [31:0] exp, input string tag);
    chipselect = 1'b1; read = 1'b1; write = 1'b0; address = a;
    step();
    idle();
    check(tag, readdata, exp);
  endtask

  initial begin
    int hold;
    int r;
    Reset = 1'b1; pio_in = 8'hFF; address = '0; writedata = '0;
    idle();
    cyc(2);
    Reset = 1'b0;
    check("rst_pio_out", {24'b0, pio_out}, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    rd_reg(2'd0, 32'hFF, "rst_data_in");
    rd_reg(2'd1, 32'h00, "rst_data_out");
    rd_reg(2'd2, 32'h00, "rst_edge");
    rd_reg(2'd3, 32'h00, "rst_mask");

    // Output register and read-only DATA_IN
    wr_reg(2'd1, 32'hFFFF_FFA5);
    check("out_a5", {24'b0, pio_out}, 32'hA5);
    rd_reg(2'd1, 32'h0000_00A5, "rd_out_a5");
    wr_reg(2'd0, 32'h12);
    rd_reg(2'd0, 32'hFF, "data_in_ro");

    // Glitch of 3 cycles is rejected
    pio_in = 8'hFE; cyc(3); pio_in = 8'hFF; cyc(8);
    rd_reg(2'd0, 32'hFF, "glitch_data_in");
    rd_reg(2'd2, 32'h00, "glitch_edge");

    // Held change: stable flips on edge 6 after the pin change
    pio_in = 8'hFE; cyc(5);
    rd_reg(2'd0, 32'hFF, "deb_edge6_old");
    rd_reg(2'd0, 32'hFE, "deb_edge7_new");
    rd_reg(2'd2, 32'h01, "deb_edge_cap");

    // Edge capture and irq
    wr_reg(2'd2, 32'hFF);
    pio_in = 8'hFF; cyc(10);
    wr_reg(2'd3, 32'h01);
    rd_reg(2'd2, 32'h00, "rise_ignored");
    pio_in = 8'hFE; cyc(6);
    check("irq_before", {31'b0, irq}, 32'h0);
    step();
    check("irq_set", {31'b0, irq}, 32'h1);
    rd_reg(2'd2, 32'h01, "edge_set");
    wr_reg(2'd2, 32'h01);
    check("irq_cleared", {31'b0, irq}, 32'h0);
    rd_reg(2'd2, 32'h00, "edge_cleared");

    // W1C in the same cycle as a new event on that bit
    pio_in = 8'hFF; cyc(10); pio_in = 8'hFE; cyc(10);
    check("irq_pre_sim", {31'b0, irq}, 32'h1);
    pio_in = 8'hFF; cyc(10); pio_in = 8'hFE; cyc(6);
    wr_reg(2'd2, 32'h01);
    check("irq_sim_setclr", {31'b0, irq}, 32'h1);
    rd_reg(2'd2, 32'h01, "edge_sim_setclr");

    // Reset mid-qualification discards the count
    wr_reg(2'd2, 32'hFF);
    pio_in = 8'hFC; cyc(4);
    Reset = 1'b1; step(); Reset = 1'b0;
    check("midrst_irq", {31'b0, irq}, 32'h0);
    rd_reg(2'd0, 32'hFF, "midrst_data_in");
    cyc(4);
    rd_reg(2'd0, 32'hFF, "requal_old");
    rd_reg(2'd0, 32'hFC, "requal_new");

    // Random traffic against the model
    hold = 0;
    for (int i = 0; i < 3000; i++) begin
      if (hold == 0) begin
        pio_in = pio_in ^ 8'($urandom & $urandom & $urandom);
        hold = $urandom_range(1, 9);
      end else begin
        hold--;
      end
      r = $urandom_range(0, 9);
      chipselect = (r != 0) && ($urandom_range(0, 7) != 0);
      read       = (r >= 4 && r <= 6) || r == 9 || r == 0;
      write      = (r >= 7);
      address    = 2'($urandom);
      writedata  = $urandom;
      Reset      = ($urandom_range(0, 399) == 0);
      step();
    end
    Reset = 1'b0;
    idle();
    cyc(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
